// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keycodes, opcodes and FSM state encoding for the keypad entry buffer
package keypad_pkg;

    localparam logic [4:0] KEY_ADD  = 5'b01010;
    localparam logic [4:0] KEY_SUB  = 5'b00011;
    localparam logic [4:0] KEY_MULT = 5'b00010;
    localparam logic [4:0] KEY_BS   = 5'b00001;
    localparam logic [4:0] KEY_CA   = 5'b01001;
    localparam logic [4:0] KEY_CE   = 5'b01100;
    localparam logic [4:0] KEY_EQ   = 5'b00100;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    typedef enum logic [2:0] {
        ST_ENTRY_A  = 3'd0,
        ST_OP_WAIT  = 3'd1,
        ST_ENTRY_B  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_SHOW     = 3'd5
    } state_t;

endpackage

// File: rtl/keypad_digit_shifter.sv
// rtl/keypad_digit_shifter.sv - hex entry register with digit count, backspace, clear and overflow
module keypad_digit_shifter #(
    parameter  int DIGITS = 8,
    localparam int W      = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [W-1:0]  load_value,
    input  logic          shift,
    input  logic          fresh,
    input  logic [3:0]    digit,
    input  logic          backspace,
    output logic [W-1:0]  entry,
    output logic [CW-1:0] digit_count,
    output logic          overflow
);

    // Priority: clear > load > digit > backspace; callers never assert two at once except with clear.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            entry       <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (load) begin
                entry       <= load_value;
                digit_count <= CW'(DIGITS);
            end else if (shift && fresh) begin
                entry       <= {{(W-4){1'b0}}, digit};
                digit_count <= (digit != 4'd0) ? CW'(1) : '0;
            end else if (shift) begin
                if (digit_count == CW'(DIGITS)) begin
                    overflow <= 1'b1;
                end else if (digit_count != '0 || digit != 4'd0) begin
                    // A leading zero would not change the value, so it is not counted.
                    entry       <= {entry[W-5:0], digit};
                    digit_count <= digit_count + CW'(1);
                end
            end else if (backspace && digit_count != '0) begin
                entry       <= entry >> 4;
                digit_count <= digit_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_entry_buffer.sv
// rtl/keypad_entry_buffer.sv - keypad operand/operator entry FSM with valid/ready hand-off to the ALU
module keypad_entry_buffer
    import keypad_pkg::*;
#(
    parameter  int DIGITS = 8,
    parameter  int OPW    = 2,
    localparam int W      = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          newkey,
    input  logic [4:0]    keycode,
    output logic          exec_valid,
    input  logic          exec_ready,
    output logic [W-1:0]  operand_a,
    output logic [W-1:0]  operand_b,
    output logic [OPW-1:0] opcode,
    input  logic          result_valid,
    input  logic [W-1:0]  result,
    output logic [W-1:0]  display,
    output logic [CW-1:0] digit_count,
    output logic          overflow,
    output logic          busy
);

    state_t         state;
    logic [W-1:0]   entry;
    logic           is_digit, is_op, is_eq, is_bs, is_ca, is_ce;
    logic [OPW-1:0] key_op;

    always_comb begin
        is_digit = 1'b0;
        is_op    = 1'b0;
        is_eq    = 1'b0;
        is_bs    = 1'b0;
        is_ca    = 1'b0;
        is_ce    = 1'b0;
        key_op   = OPW'(OP_ADD);
        if (newkey) begin
            if (keycode[4]) begin
                is_digit = 1'b1;
            end else begin
                case (keycode)
                    KEY_ADD:  begin is_op = 1'b1; key_op = OPW'(OP_ADD);  end
                    KEY_SUB:  begin is_op = 1'b1; key_op = OPW'(OP_SUB);  end
                    KEY_MULT: begin is_op = 1'b1; key_op = OPW'(OP_MULT); end
                    KEY_BS:   is_bs = 1'b1;
                    KEY_CA:   is_ca = 1'b1;
                    KEY_CE:   is_ce = 1'b1;
                    KEY_EQ:   is_eq = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    logic in_entry, fresh_state;
    logic sh_clear, sh_load, sh_shift, sh_bs;

    assign in_entry    = (state == ST_ENTRY_A) || (state == ST_ENTRY_B);
    assign fresh_state = (state == ST_OP_WAIT) || (state == ST_SHOW);
    // The entry register is also emptied when its value moves into operand_a.
    assign sh_clear = is_ca
                   || (is_ce && (in_entry || fresh_state))
                   || (is_op && ((state == ST_ENTRY_A) || (state == ST_SHOW)));
    assign sh_load  = (state == ST_WAIT_RES) && result_valid;
    assign sh_shift = is_digit && (in_entry || fresh_state);
    assign sh_bs    = is_bs && in_entry;

    keypad_digit_shifter #(.DIGITS(DIGITS)) u_shifter (
        .clock       (clock),
        .reset       (reset),
        .clear       (sh_clear),
        .load        (sh_load),
        .load_value  (result),
        .shift       (sh_shift),
        .fresh       (fresh_state),
        .digit       (keycode[3:0]),
        .backspace   (sh_bs),
        .entry       (entry),
        .digit_count (digit_count),
        .overflow    (overflow)
    );

    always_ff @(posedge clock) begin
        if (reset || is_ca) begin
            state      <= ST_ENTRY_A;
            operand_a  <= '0;
            operand_b  <= '0;
            opcode     <= OPW'(OP_ADD);
            exec_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_ENTRY_A: begin
                    if (is_op) begin
                        operand_a <= entry;
                        opcode    <= key_op;
                        state     <= ST_OP_WAIT;
                    end
                end
                ST_OP_WAIT: begin
                    if (is_op) begin
                        opcode <= key_op;
                    end else if (is_digit) begin
                        state <= ST_ENTRY_B;
                    end else if (is_eq) begin
                        operand_b  <= operand_a;
                        exec_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_ENTRY_B: begin
                    if (is_eq) begin
                        operand_b  <= entry;
                        exec_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_valid && exec_ready) begin
                        exec_valid <= 1'b0;
                        state      <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (result_valid) begin
                        busy  <= 1'b0;
                        state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (is_op) begin
                        operand_a <= entry;
                        opcode    <= key_op;
                        state     <= ST_OP_WAIT;
                    end else if (is_digit || is_ce) begin
                        state <= ST_ENTRY_A;
                    end
                end
                default: state <= ST_ENTRY_A;
            endcase
        end
    end

    always_comb begin
        case (state)
            ST_OP_WAIT, ST_EXEC, ST_WAIT_RES: display = operand_a;
            default:                          display = entry;
        endcase
    end

endmodule
